two_way_karatsuba_seq: RTL

Parametrised, handshaked, multi-cycle GF(2) (carry-less) polynomial multiplier using one level of 2-way Karatsuba split. Three half-width sub-products are accumulated digit-serially in parallel, then recombined into the full unreduced 2N-bit product. The block is the generic-width successor of the fixed-size 2-way Karatsuba multipliers in the large-multiplier library. It sits in front of a field-reduction stage in ECC/PQC datapaths.

---
 rtl/two_way_karatsuba_seq.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/two_way_karatsuba_seq.sv
// two_way_karatsuba_seq: digit-serial GF(2) multiplier, one 2-way Karatsuba level.
// Three half-width carry-less products accumulate in parallel, then recombine.
module two_way_karatsuba_seq #(
   parameter int N     = 571,
   parameter int DIGIT = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] c
);

   localparam int H  = (N + 1) / 2;
   localparam int P  = 2 * H - 1;
   localparam int S  = (H + DIGIT - 1) / DIGIT;
   localparam int CW = $clog2(S + 1);
   localparam int CN = 2 * N;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_COMB = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_next;

   // Multiplier operands shift right so bit 0 is always the current digit.
   logic [H-1:0]   r_xlo;
   logic [H-1:0]   r_xhi;
   logic [H-1:0]   r_xmid;

   // Multiplicands shift left so they are pre-aligned to the digit weight.
   logic [P-1:0]   r_ylo;
   logic [P-1:0]   r_yhi;
   logic [P-1:0]   r_ymid;

   logic [P-1:0]   r_plo;
   logic [P-1:0]   r_phi;
   logic [P-1:0]   r_pmid;

   logic [CW-1:0]  r_k;
   logic [CN-1:0]  r_c;
   logic           r_done;

   logic [H-1:0]   w_alo;
   logic [H-1:0]   w_ahi;
   logic [H-1:0]   w_blo;
   logic [H-1:0]   w_bhi;
   logic [P-1:0]   w_step_lo;
   logic [P-1:0]   w_step_hi;
   logic [P-1:0]   w_step_mid;
   logic [P-1:0]   w_mid;
   logic [CN-1:0]  w_c;
   logic           w_last;
   logic           w_accept;
   logic           w_mul;
   logic           w_comb;

   // One digit of a carry-less product: XOR of shifted multiplicands.
   function automatic logic [P-1:0] f_digit(
      input logic [H-1:0] x,
      input logic [P-1:0] y
   );
      logic [P-1:0] s;
      s = '0;
      for (int j = 0; j < DIGIT; j++) begin
         if (x[j]) begin
            s = s ^ (y << j);
         end
      end
      return s;
   endfunction

   assign w_alo = a[H-1:0];
   assign w_ahi = H'(a[N-1:H]);
   assign w_blo = b[H-1:0];
   assign w_bhi = H'(b[N-1:H]);

   assign w_step_lo  = f_digit(r_xlo,  r_ylo);
   assign w_step_hi  = f_digit(r_xhi,  r_yhi);
   assign w_step_mid = f_digit(r_xmid, r_ymid);

   assign w_last   = (r_k == CW'(S - 1));
   assign w_accept = (r_state == ST_IDLE) && start;
   assign w_mul    = (r_state == ST_MUL);
   assign w_comb   = (r_state == ST_COMB);

   // Karatsuba middle term: only XOR, so the "subtraction" is free.
   assign w_mid = r_pmid ^ r_phi ^ r_plo;

   // Recombine at 2N width; bits beyond 2N are always zero here.
   assign w_c = (CN'(r_phi) << (2 * H))
              ^ (CN'(w_mid) << H)
              ^ CN'(r_plo);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next = ST_MUL;
            end
         end
         ST_MUL: begin
            if (w_last) begin
               w_next = ST_COMB;
            end
         end
         ST_COMB: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Output decode from state.
   always_comb begin
      busy = 1'b0;
      unique case (r_state)
         ST_IDLE: busy = 1'b0;
         ST_MUL:  busy = 1'b1;
         ST_COMB: busy = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   // Operand capture and digit-serial accumulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_xlo  <= '0;
         r_xhi  <= '0;
         r_xmid <= '0;
         r_ylo  <= '0;
         r_yhi  <= '0;
         r_ymid <= '0;
         r_plo  <= '0;
         r_phi  <= '0;
         r_pmid <= '0;
         r_k    <= '0;
      end else if (w_accept) begin
         r_xlo  <= w_alo;
         r_xhi  <= w_ahi;
         r_xmid <= w_ahi ^ w_alo;
         r_ylo  <= P'(w_blo);
         r_yhi  <= P'(w_bhi);
         r_ymid <= P'(w_bhi ^ w_blo);
         r_plo  <= '0;
         r_phi  <= '0;
         r_pmid <= '0;
         r_k    <= '0;
      end else if (w_mul) begin
         r_plo  <= r_plo  ^ w_step_lo;
         r_phi  <= r_phi  ^ w_step_hi;
         r_pmid <= r_pmid ^ w_step_mid;
         r_xlo  <= r_xlo  >> DIGIT;
         r_xhi  <= r_xhi  >> DIGIT;
         r_xmid <= r_xmid >> DIGIT;
         r_ylo  <= r_ylo  << DIGIT;
         r_yhi  <= r_yhi  << DIGIT;
         r_ymid <= r_ymid << DIGIT;
         r_k    <= r_k + CW'(1);
      end
   end

   // Result register and done pulse; c holds until the next combine.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_c    <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_comb;
         if (w_comb) begin
            r_c <= w_c;
         end
      end
   end

   assign done = r_done;
   assign c    = r_c;

endmodule
